hilo_sched: RTL and testbench

- Multi-cycle multiply/divide unit and HI/LO scheduler for the pipelined MIPS CPU; sits in stage E beside the ALU.
- Accepts the E-stage HILOType op and operands, then runs mult/multu/div/divu over a fixed latency.
- Owns the HI/LO registers, serves mfhi/mflo reads and mthi/mtlo writes.
- Raises a stall request to the hazard unit while a D-stage md/mf/mt instruction would collide with an in-flight or starting operation.

---
 rtl/hilo_sched_pkg.sv | 28 ++
 rtl/md_arith.sv | 63 ++++++
 rtl/hilo_sched.sv | 123 ++++++++++++
 tb/tb_hilo_sched.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/hilo_sched_pkg.sv
// Shared definitions for the HI/LO multiply/divide scheduler:
// op codes, default latencies and the sequencer state type.
package hilo_sched_pkg;

    localparam logic [3:0] HILO_MULT  = 4'd0;
    localparam logic [3:0] HILO_MULTU = 4'd1;
    localparam logic [3:0] HILO_DIV   = 4'd2;
    localparam logic [3:0] HILO_DIVU  = 4'd3;
    localparam logic [3:0] HILO_MFHI  = 4'd4;
    localparam logic [3:0] HILO_MFLO  = 4'd5;
    localparam logic [3:0] HILO_MTHI  = 4'd6;
    localparam logic [3:0] HILO_MTLO  = 4'd7;
    localparam logic [3:0] HILO_NONE  = 4'hF;

    localparam int MULT_LAT_DEF = 5;
    localparam int DIV_LAT_DEF  = 10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

    // mult/multu/div/divu occupy codes 0..3
    function automatic logic is_md_op(input logic [3:0] op);
        return (op[3:2] == 2'b00);
    endfunction

endpackage

// File: rtl/md_arith.sv
// Combinational multiply/divide datapath producing the 64-bit {hi,lo} result.
// A zero divisor passes the current HI/LO through so the commit leaves them unchanged.
module md_arith
    import hilo_sched_pkg::*;
(
    input  logic [3:0]  i_op,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    input  logic [31:0] i_hi,
    input  logic [31:0] i_lo,
    output logic [31:0] o_hi,
    output logic [31:0] o_lo
);

    logic        w_signed;
    logic [63:0] w_ma;
    logic [63:0] w_mb;
    logic [63:0] w_prod;
    logic        w_neg_a;
    logic        w_neg_b;
    logic [31:0] w_ua;
    logic [31:0] w_ub;
    logic [31:0] w_uq;
    logic [31:0] w_ur;
    logic [31:0] w_q;
    logic [31:0] w_r;

    assign w_signed = (i_op == HILO_MULT) || (i_op == HILO_DIV);

    // Low 64 bits of a product of sign-extended operands equal the signed product
    assign w_ma   = {{32{w_signed & i_a[31]}}, i_a};
    assign w_mb   = {{32{w_signed & i_b[31]}}, i_b};
    assign w_prod = w_ma * w_mb;

    // Signed divide on magnitudes; 0x80000000 / -1 wraps back to 0x80000000 with remainder 0
    assign w_neg_a = w_signed & i_a[31];
    assign w_neg_b = w_signed & i_b[31];
    assign w_ua    = w_neg_a ? (32'd0 - i_a) : i_a;
    assign w_ub    = w_neg_b ? (32'd0 - i_b) : i_b;
    assign w_uq    = w_ua / w_ub;
    assign w_ur    = w_ua % w_ub;
    assign w_q     = (w_neg_a ^ w_neg_b) ? (32'd0 - w_uq) : w_uq;
    assign w_r     = w_neg_a ? (32'd0 - w_ur) : w_ur;

    always_comb begin
        o_hi = i_hi;
        o_lo = i_lo;
        case (i_op)
            HILO_MULT, HILO_MULTU: begin
                o_hi = w_prod[63:32];
                o_lo = w_prod[31:0];
            end
            HILO_DIV, HILO_DIVU: begin
                if (i_b != 32'd0) begin
                    o_hi = w_r;
                    o_lo = w_q;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/hilo_sched.sv
// E-stage multiply/divide scheduler: owns HI/LO, sequences fixed-latency md ops
// with a down-counter and requests a D-stage stall while an op is starting or in flight.
//
// state   | meaning
// --------+------------------------------------------------------------
// ST_IDLE | cnt==0, busy=0; accepts md start and mthi/mtlo writes
// ST_BUSY | cnt!=0, busy=1; counts down, commits result when cnt==1
module hilo_sched
    import hilo_sched_pkg::*;
#(
    parameter int MULT_LAT = MULT_LAT_DEF,
    parameter int DIV_LAT  = DIV_LAT_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  E_HILOType,
    input  logic [31:0] E_A,
    input  logic [31:0] E_B,
    input  logic        D_hilo_use,
    output logic        start,
    output logic        busy,
    output logic        stall,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] E_HILO_out
);

    localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);

    state_e             r_state;
    state_e             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [31:0]        r_hi;
    logic [31:0]        r_lo;
    logic [31:0]        r_hi_tmp;
    logic [31:0]        r_lo_tmp;

    logic               w_load;
    logic               w_commit;
    logic               w_wr_hi;
    logic               w_wr_lo;
    logic               w_is_div;
    logic [CNT_W-1:0]   w_lat;
    logic [31:0]        w_hi_res;
    logic [31:0]        w_lo_res;

    md_arith u_md_arith (
        .i_op (E_HILOType),
        .i_a  (E_A),
        .i_b  (E_B),
        .i_hi (r_hi),
        .i_lo (r_lo),
        .o_hi (w_hi_res),
        .o_lo (w_lo_res)
    );

    assign start    = is_md_op(E_HILOType);
    assign stall    = D_hilo_use & (start | busy);
    assign HI       = r_hi;
    assign LO       = r_lo;
    assign w_is_div = (E_HILOType == HILO_DIV) || (E_HILOType == HILO_DIVU);
    assign w_lat    = w_is_div ? CNT_W'(DIV_LAT) : CNT_W'(MULT_LAT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (start) w_state_nxt = ST_BUSY;
            ST_BUSY: if (r_cnt == CNT_W'(1)) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Ops arriving while busy are dropped; the hazard unit should never let them through
    always_comb begin
        busy     = (r_state == ST_BUSY);
        w_load   = (r_state == ST_IDLE) && start;
        w_commit = (r_state == ST_BUSY) && (r_cnt == CNT_W'(1));
        w_wr_hi  = (r_state == ST_IDLE) && (E_HILOType == HILO_MTHI);
        w_wr_lo  = (r_state == ST_IDLE) && (E_HILOType == HILO_MTLO);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt    <= '0;
            r_hi     <= 32'd0;
            r_lo     <= 32'd0;
            r_hi_tmp <= 32'd0;
            r_lo_tmp <= 32'd0;
        end else begin
            if (w_load) begin
                r_cnt    <= w_lat;
                r_hi_tmp <= w_hi_res;
                r_lo_tmp <= w_lo_res;
            end else if (busy) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
            if (w_commit) begin
                r_hi <= r_hi_tmp;
                r_lo <= r_lo_tmp;
            end
            if (w_wr_hi) r_hi <= E_A;
            if (w_wr_lo) r_lo <= E_A;
        end
    end

    always_comb begin
        case (E_HILOType)
            HILO_MFHI: E_HILO_out = r_hi;
            HILO_MFLO: E_HILO_out = r_lo;
            default:   E_HILO_out = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_hilo_sched.sv
// Directed bench for hilo_sched: md latencies, results, hazard stall, mt/mf and async reset.
module tb_hilo_sched;
    import hilo_sched_pkg::*;

    logic        clk;
    logic        reset;
    logic [3:0]  E_HILOType;
    logic [31:0] E_A;
    logic [31:0] E_B;
    logic        D_hilo_use;
    logic        start;
    logic        busy;
    logic        stall;
    logic [31:0] HI;
    logic [31:0] LO;
    logic [31:0] E_HILO_out;

    int n_asserts = 0;
    int n_fail    = 0;

    hilo_sched #(.MULT_LAT(5), .DIV_LAT(10)) dut (
        .clk        (clk),
        .reset      (reset),
        .E_HILOType (E_HILOType),
        .E_A        (E_A),
        .E_B        (E_B),
        .D_hilo_use (D_hilo_use),
        .start      (start),
        .busy       (busy),
        .stall      (stall),
        .HI         (HI),
        .LO         (LO),
        .E_HILO_out (E_HILO_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic d_use);
        E_HILOType = op;
        E_A        = a;
        E_B        = b;
        D_hilo_use = d_use;
        #1;
    endtask

    // Clock the issued op in, then expect exactly lat busy cycles with HI held
    task automatic wait_op(input string tag, input int lat, input logic [31:0] hold_hi);
        tick();
        E_HILOType = HILO_NONE;
        for (int k = 0; k < lat; k++) begin
            chk({tag, " busy"}, {31'd0, busy}, 32'd1);
            chk({tag, " hi_hold"}, HI, hold_hi);
            tick();
        end
        chk({tag, " done"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        reset      = 1'b1;
        E_HILOType = HILO_NONE;
        E_A        = 32'd0;
        E_B        = 32'd0;
        D_hilo_use = 1'b0;
        #12;
        chk("rst HI", HI, 32'd0);
        chk("rst LO", LO, 32'd0);
        chk("rst busy", {31'd0, busy}, 32'd0);
        chk("rst stall", {31'd0, stall}, 32'd0);
        chk("rst start", {31'd0, start}, 32'd0);
        reset = 1'b0;
        tick();

        // mult -3 * 5
        issue(HILO_MULT, 32'hFFFFFFFD, 32'd5, 1'b0);
        chk("mult start", {31'd0, start}, 32'd1);
        chk("mult stall", {31'd0, stall}, 32'd0);
        wait_op("mult", 5, 32'd0);
        chk("mult HI", HI, 32'hFFFFFFFF);
        chk("mult LO", LO, 32'hFFFFFFF1);

        // multu 0xFFFFFFFF * 2, then mflo/mfhi
        issue(HILO_MULTU, 32'hFFFFFFFF, 32'd2, 1'b0);
        wait_op("multu", 5, 32'hFFFFFFFF);
        chk("multu HI", HI, 32'h00000001);
        chk("multu LO", LO, 32'hFFFFFFFE);
        issue(HILO_MFLO, 32'd0, 32'd0, 1'b0);
        chk("mflo out", E_HILO_out, 32'hFFFFFFFE);
        issue(HILO_MFHI, 32'd0, 32'd0, 1'b0);
        chk("mfhi out", E_HILO_out, 32'h00000001);
        issue(HILO_NONE, 32'd0, 32'd0, 1'b0);
        chk("none out", E_HILO_out, 32'd0);

        // div -7 / 2
        issue(HILO_DIV, 32'hFFFFFFF9, 32'd2, 1'b0);
        wait_op("div", 10, 32'h00000001);
        chk("div HI", HI, 32'hFFFFFFFF);
        chk("div LO", LO, 32'hFFFFFFFD);

        // divu by zero: full latency, HI/LO unchanged
        issue(HILO_DIVU, 32'd7, 32'd0, 1'b0);
        wait_op("divu0", 10, 32'hFFFFFFFF);
        chk("divu0 HI", HI, 32'hFFFFFFFF);
        chk("divu0 LO", LO, 32'hFFFFFFFD);

        // div 7 / -2: remainder follows the dividend
        issue(HILO_DIV, 32'd7, 32'hFFFFFFFE, 1'b0);
        wait_op("divneg", 10, 32'hFFFFFFFF);
        chk("divneg HI", HI, 32'h00000001);
        chk("divneg LO", LO, 32'hFFFFFFFD);

        // overflow case 0x80000000 / -1
        issue(HILO_DIV, 32'h80000000, 32'hFFFFFFFF, 1'b0);
        wait_op("divovf", 10, 32'h00000001);
        chk("divovf HI", HI, 32'h00000000);
        chk("divovf LO", LO, 32'h80000000);

        // divu 0xFFFFFFFF / 10
        issue(HILO_DIVU, 32'hFFFFFFFF, 32'd10, 1'b0);
        wait_op("divu", 10, 32'h00000000);
        chk("divu HI", HI, 32'h00000005);
        chk("divu LO", LO, 32'h19999999);

        // hazard: mult in E with mfhi waiting in D
        issue(HILO_MULT, 32'h00010000, 32'h00030000, 1'b1);
        chk("haz start stall", {31'd0, stall}, 32'd1);
        tick();
        E_HILOType = HILO_NONE;
        for (int k = 0; k < 5; k++) begin
            chk("haz busy", {31'd0, busy}, 32'd1);
            chk("haz stall", {31'd0, stall}, 32'd1);
            tick();
        end
        chk("haz release busy", {31'd0, busy}, 32'd0);
        chk("haz release stall", {31'd0, stall}, 32'd0);
        tick();
        issue(HILO_MFHI, 32'd0, 32'd0, 1'b0);
        chk("haz mfhi", E_HILO_out, 32'h00000003);
        chk("haz LO", LO, 32'h00000000);

        // mthi / mtlo while idle
        issue(HILO_MTHI, 32'h12345678, 32'd0, 1'b0);
        chk("mthi start", {31'd0, start}, 32'd0);
        tick();
        E_HILOType = HILO_NONE;
        chk("mthi HI", HI, 32'h12345678);
        chk("mthi LO", LO, 32'h00000000);
        chk("mthi busy", {31'd0, busy}, 32'd0);
        issue(HILO_MTLO, 32'hCAFEBABE, 32'd0, 1'b0);
        tick();
        E_HILOType = HILO_NONE;
        chk("mtlo LO", LO, 32'hCAFEBABE);
        chk("mtlo HI", HI, 32'h12345678);

        // unused code behaves as a bubble
        issue(4'h9, 32'hDEADBEEF, 32'd3, 1'b1);
        chk("code9 start", {31'd0, start}, 32'd0);
        chk("code9 stall", {31'd0, stall}, 32'd0);
        tick();
        E_HILOType = HILO_NONE;
        D_hilo_use = 1'b0;
        chk("code9 busy", {31'd0, busy}, 32'd0);
        chk("code9 HI", HI, 32'h12345678);
        chk("code9 LO", LO, 32'hCAFEBABE);

        // async reset in the third busy cycle of a div
        issue(HILO_DIV, 32'd100, 32'd7, 1'b0);
        tick();
        E_HILOType = HILO_NONE;
        tick();
        tick();
        chk("rstmid busy before", {31'd0, busy}, 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("rstmid busy", {31'd0, busy}, 32'd0);
        chk("rstmid HI", HI, 32'd0);
        chk("rstmid LO", LO, 32'd0);
        #3;
        reset = 1'b0;
        repeat (12) tick();
        chk("rstmid no commit busy", {31'd0, busy}, 32'd0);
        chk("rstmid no commit HI", HI, 32'd0);
        chk("rstmid no commit LO", LO, 32'd0);

        issue(HILO_MULT, 32'd7, 32'd6, 1'b0);
        wait_op("post mult", 5, 32'd0);
        chk("post mult HI", HI, 32'd0);
        chk("post mult LO", LO, 32'd42);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
